// File: rtl/seq_mult_param.sv
// ---------------------------------------------------------------------------
// seq_mult_param
//   Iterative shift-add multiplier. One multiply takes WIDTH+1 cycles from the
//   start cycle to the done pulse, regardless of operand values. Operands can
//   be treated as unsigned or two's complement, selected per operation.
//
//   Signed operations use sign-magnitude internally. Each operand is reduced
//   to its WIDTH-bit magnitude when the operation is accepted. The magnitudes
//   are multiplied unsigned, and the 2*WIDTH-bit product is negated at the end
//   when the operand signs differ.
//
// Parameters
//   WIDTH      operand width (>= 2); the product is 2*WIDTH bits
//   SIGNED_EN  1: signed_mode is honoured; 0: always unsigned
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        operation request, sampled only while busy=0
//   signed_mode  1: a/b are two's complement (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier (sampled with start)
//   busy         high while iterating
//   done         one-cycle pulse when result is valid
//   result       product; holds until the next operation completes
// ---------------------------------------------------------------------------
module seq_mult_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                accept;
    logic                last_iter;
    logic                sm_eff;

    // Iteration datapath
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH-1:0]  prod;
    logic                neg;
    logic [WIDTH:0]      psum;
    logic [2*WIDTH-1:0]  prod_step;

    // Magnitude of a two's-complement operand. When signed handling is
    // disabled, the operand is passed through unchanged. The most negative
    // value maps to 2^(WIDTH-1), which still fits as a WIDTH-bit unsigned.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic signed [WIDTH-1:0] x,
        input logic                    is_signed
    );
        logic [WIDTH-1:0] m;
        m = x;
        if (is_signed && x[WIDTH-1]) begin
            m = -x;
        end
        return m;
    endfunction

    // Conditional two's-complement negation of the full-width product.
    // A zero product stays zero, so no negative zero can appear.
    function automatic logic [2*WIDTH-1:0] apply_sign(
        input logic [2*WIDTH-1:0] p,
        input logic               negate
    );
        logic [2*WIDTH-1:0] r;
        r = p;
        if (negate) begin
            r = ~p + (2*WIDTH)'(1);
        end
        return r;
    endfunction

    assign sm_eff = SIGNED_EN && signed_mode;

    // One shift-add step (right-shifting accumulator form). The low half of
    // prod starts out holding the multiplier, and its LSB selects whether the
    // multiplicand is added to the upper half. The carry out of that add
    // shifts down into the top bit of the product.
    assign psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {psum, prod[WIDTH-1:1]};

    assign last_iter = (state == CALC) && (cnt == LAST);

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                    cnt_nxt   = '0;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // Control state and the visible result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (last_iter) begin
                result <= apply_sign(prod_step, neg);
            end
        end
    end

    // Operand capture and iteration. These registers are not reset: they are
    // only observed while in CALC, and CALC is always entered through accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand <= magnitude(a, sm_eff);
            prod  <= {{WIDTH{1'b0}}, magnitude(b, sm_eff)};
            neg   <= sm_eff && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == CALC) begin
            prod  <= prod_step;
        end
    end

endmodule
